// File: rtl/lsu_mem_pkg.sv
// Shared types for the data-memory access stage: op encoding, FSM states,
// request/response bundles and misaligned-access cause codes.
package lsu_mem_pkg;

    typedef struct packed {
        logic lb;
        logic lh;
        logic lw;
        logic lbu;
        logic lhu;
        logic sb;
        logic sh;
        logic sw;
    } lsu_op_type;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } lsu_mem_state_type;

    localparam logic [3:0] ECAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] ECAUSE_STORE_MISALIGNED = 4'd6;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] sdata;
        lsu_op_type  lsu_op;
    } lsu_mem_in_type;

    typedef struct packed {
        logic        valid;
        logic [31:0] ldata;
        logic [3:0]  byteenable;
        lsu_op_type  lsu_op;
        logic        exc;
        logic [3:0]  ecause;
        logic [31:0] etval;
    } lsu_mem_out_type;

    function automatic logic op_is_load(input lsu_op_type op);
        return op.lb | op.lh | op.lw | op.lbu | op.lhu;
    endfunction

    function automatic logic op_is_store(input lsu_op_type op);
        return op.sb | op.sh | op.sw;
    endfunction

endpackage

// File: rtl/lsu_mem_align.sv
// Combinational access decode: byte enables, store-lane replication and
// misaligned detection from the low address bits and the op.
module lsu_align
    import lsu_mem_pkg::*;
(
    input  logic [1:0]  addr_low,
    input  logic [31:0] sdata,
    input  lsu_op_type  lsu_op,
    output logic [3:0]  byteenable,
    output logic [31:0] wdata,
    output logic        misaligned
);

    logic is_byte;
    logic is_half;
    logic is_word;

    assign is_byte = lsu_op.lb | lsu_op.lbu | lsu_op.sb;
    assign is_half = lsu_op.lh | lsu_op.lhu | lsu_op.sh;
    assign is_word = lsu_op.lw | lsu_op.sw;

    always_comb begin
        byteenable = 4'h0;
        wdata      = sdata;
        misaligned = 1'b0;
        if (is_byte) begin
            byteenable = 4'b0001 << addr_low;
            wdata      = {4{sdata[7:0]}};
        end else if (is_half) begin
            byteenable = 4'b0011 << addr_low;
            wdata      = {2{sdata[15:0]}};
            misaligned = addr_low[0];
        end else if (is_word) begin
            byteenable = 4'hF;
            misaligned = (addr_low != 2'b00);
        end
    end

endmodule

// File: rtl/lsu_mem.sv
// Data-memory access stage: one load/store per request over a valid/ready bus.
// Aligned: resp >= 2 cycles after accept; misaligned: resp next cycle, no bus.
module lsu_mem
    import lsu_mem_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_sdata,
    input  lsu_op_type  req_lsu_op,
    input  logic        flush,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_ldata,
    output logic [3:0]  resp_byteenable,
    output lsu_op_type  resp_lsu_op,
    output logic        resp_exc,
    output logic [3:0]  resp_ecause,
    output logic [31:0] resp_etval
);

    lsu_mem_state_type state, state_next;
    lsu_mem_in_type    req;
    lsu_mem_out_type   resp_q;

    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_wstrb_q;
    logic [3:0]  be_q;
    lsu_op_type  op_q;

    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic        al_mis;

    logic accept;
    logic mis_resp;
    logic done;

    assign req = '{valid: req_valid, addr: req_addr, sdata: req_sdata, lsu_op: req_lsu_op};

    lsu_align u_align (
        .addr_low   (req.addr[1:0]),
        .sdata      (req.sdata),
        .lsu_op     (req.lsu_op),
        .byteenable (al_be),
        .wdata      (al_wdata),
        .misaligned (al_mis)
    );

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        mis_resp   = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (req.valid && !flush) begin
                    if (al_mis) begin
                        mis_resp = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                // The bus handshake is always completed; flush only drops the response.
                if (mem_ready) begin
                    state_next = IDLE;
                    done       = !flush;
                end else if (flush) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            resp_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            be_q        <= '0;
            op_q        <= '0;
        end else begin
            state        <= state_next;
            resp_q.valid <= mis_resp | done;
            if (accept) begin
                mem_addr_q  <= {req.addr[31:2], 2'b00};
                mem_wdata_q <= al_wdata;
                mem_wstrb_q <= op_is_store(req.lsu_op) ? al_be : 4'h0;
                be_q        <= al_be;
                op_q        <= req.lsu_op;
            end
            if (mis_resp) begin
                resp_q.ldata      <= '0;
                resp_q.byteenable <= al_be;
                resp_q.lsu_op     <= req.lsu_op;
                resp_q.exc        <= 1'b1;
                resp_q.ecause     <= op_is_load(req.lsu_op) ? ECAUSE_LOAD_MISALIGNED
                                                            : ECAUSE_STORE_MISALIGNED;
                resp_q.etval      <= req.addr;
            end
            if (done) begin
                resp_q.ldata      <= op_is_load(op_q) ? mem_rdata : 32'h0;
                resp_q.byteenable <= be_q;
                resp_q.lsu_op     <= op_q;
                resp_q.exc        <= 1'b0;
                resp_q.ecause     <= 4'h0;
                resp_q.etval      <= 32'h0;
            end
        end
    end

    assign req_ready       = (state == IDLE);
    assign mem_valid       = (state != IDLE);
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;
    assign mem_wstrb       = mem_wstrb_q;
    // A flush arriving with a pending pulse kills it before lsu can see it.
    assign resp_valid      = resp_q.valid & ~flush;
    assign resp_ldata      = resp_q.ldata;
    assign resp_byteenable = resp_q.byteenable;
    assign resp_lsu_op     = resp_q.lsu_op;
    assign resp_exc        = resp_q.exc;
    assign resp_ecause     = resp_q.ecause;
    assign resp_etval      = resp_q.etval;

endmodule

// File: doc/lsu_mem.md
# lsu_mem

`lsu_mem` is the data-memory access stage that sits directly upstream of `lsu`. It accepts one load or store per request from execute and derives the byte-enable pattern. It aligns store data, runs a valid/ready transaction on the data bus, and hands the raw read word, byte-enable and `lsu_op` to `lsu` for extraction and sign extension. It also detects misaligned accesses and supports pipeline flush.

## Interface
Parameters:
- none.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clock` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: execute presents an access.
- `req_ready` out 1: block can accept; high only in IDLE.
- `req_addr` in 32: byte address.
- `req_sdata` in 32: store data, right-justified.
- `req_lsu_op` in `lsu_op_type`: one-hot among lb/lh/lw/lbu/lhu/sb/sh/sw.
- `flush` in 1: kill the current and pending access.
- `mem_valid` out 1: bus request.
- `mem_ready` in 1: bus completes the request.
- `mem_addr` out 32: word-aligned address, `{req_addr[31:2],2'b00}`.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_wstrb` out 4: write strobes; 0 for loads.
- `mem_rdata` in 32: read word, valid with `mem_ready`.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_ldata` out 32: captured `mem_rdata`; 0 for stores.
- `resp_byteenable` out 4: byte enable of the access, for `lsu`.
- `resp_lsu_op` out `lsu_op_type`: op of the completed access.
- `resp_exc` out 1: misaligned access.
- `resp_ecause` out 4: 4 = load misaligned, 6 = store misaligned.
- `resp_etval` out 32: faulting address.

## Operation
- FSM states: IDLE, WAIT, DRAIN. Reset enters IDLE.
- Byte enable:
  - byte access: `4'b0001 << addr[1:0]`.
  - half access: `4'b0011 << addr[1:0]`.
  - word access: `4'hF`.
- Store data: sb gives `{4{sdata[7:0]}}`; sh gives `{2{sdata[15:0]}}`; sw gives sdata.
- Misaligned: a half access with `addr[0]=1`, or a word access with `addr[1:0]!=0`.
- IDLE, on `req_valid` with no `flush`:
  - Misaligned: no bus request. Next cycle, pulse `resp_valid` with `resp_exc=1`, the matching cause, and `etval=req_addr`. Stay in IDLE.
  - Otherwise: register addr, wdata, wstrb, byteenable and op. Assert `mem_valid` next cycle and go to WAIT.
- WAIT:
  - `mem_*` outputs stay stable until `mem_ready`.
  - On `mem_ready`, capture rdata (loads) and go to IDLE. The next cycle pulses `resp_valid`, `resp_exc=0`.
- `flush`:
  - In IDLE: ignore any request presented in the same cycle, and suppress any queued response pulse.
  - In WAIT: the bus transaction is never abandoned. Go to DRAIN and keep `mem_valid` asserted. On `mem_ready`, return to IDLE with no `resp_valid`.
  - Flush in the same cycle as `mem_ready` in WAIT: go to IDLE and suppress the response.
  - In DRAIN: no additional effect.
- Resp payload registers hold their value between pulses. Only `resp_valid` qualifies them.

## Timing
- Request accepted at cycle t → `mem_valid` high at t+1.
- `mem_ready` at cycle k → `mem_valid` low at k+1, `resp_valid` high at k+1 only.
- Minimum aligned latency: 2 cycles (ready at t+1 → resp at t+2).
- Misaligned access: resp at t+1, zero bus cycles.
- Back-to-back: a new request can be accepted in the cycle `resp_valid` is high (state is IDLE).
- Reset values:
  - all outputs 0; `resp_lsu_op` all-zero; `req_ready=1` after reset.
- Reset mid-WAIT: drop the transaction and deassert `mem_valid` next cycle. Reset dominates `flush` and `mem_ready`.

## Structure
- `wires` package gains `lsu_mem_in_type`/`lsu_mem_out_type` structs and an FSM state enum.
- `lsu_op_type` is reused unchanged.
- Misaligned cause codes 4 and 6 become package constants.
- One combinational sub-module, `lsu_align`: computes byteenable, wdata replication and the misaligned flag from addr, sdata and op. Instantiated once.

## Test plan
- lbu at 0x1003, ready at the first bus cycle:
  - `mem_addr=0x1000`, `wstrb=0`;
  - `resp_byteenable=4'h8` two cycles after acceptance;
  - `resp_ldata` equals rdata 0xAABBCCDD.
- sh of 0x1234_5678 at 0x2002, ready after 3 wait cycles:
  - `mem_wdata=0x5678_5678`, `wstrb=4'hC`, held stable for all 4 bus cycles;
  - single `resp_valid`.
- lw at 0x3001:
  - no `mem_valid`;
  - resp at t+1 with `exc=1`, `ecause=4`, `etval=0x3001`.
- sw at 0x4002: `exc=1`, `ecause=6`, `etval=0x4002`.
- lw issued, `flush` in the second WAIT cycle, ready 2 cycles later:
  - `mem_valid` held until ready;
  - no `resp_valid`;
  - `req_ready` returns the cycle after ready.
- Reset asserted in WAIT with `mem_ready=1` same cycle:
  - next cycle all outputs 0, state IDLE, no `resp_valid`.
